// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings and helpers for the pipeline hazard controller
package mips_pkg;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

    // A live writer in a later stage produces register s; $zero never matches.
    function automatic logic reg_match(input logic [4:0] s, input logic valid,
                                       input logic wr, input logic [4:0] rd);
        return valid & wr & (rd != 5'd0) & (rd == s);
    endfunction
endpackage

// File: rtl/muldiv_tracker.sv
// muldiv_tracker: IDLE/BUSY tracker for the multi-cycle mult/div unit
//   clk, reset       clock, asynchronous active-high reset
//   muldiv_start_ex  mult/div issued in EX this cycle
//   muldiv_busy      mult/div in flight (rises the cycle after start)
module muldiv_tracker
    import mips_pkg::*;
#(
    parameter int MULDIV_LAT = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic muldiv_start_ex,
    output logic muldiv_busy
);
    md_state_t        state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (muldiv_start_ex) begin
                state <= BUSY;
                cnt   <= CNT_W'(MULDIV_LAT - 1);
            end
        end else begin
            cnt   <= cnt - CNT_W'(1);
            state <= (cnt == CNT_W'(1)) ? IDLE : BUSY;
        end
    end

    assign muldiv_busy = (state == BUSY);

    // A new op issued while one is in flight is dropped; the stall logic must prevent it.
    assert property (@(posedge clk) disable iff (reset) !(muldiv_start_ex && state == BUSY));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, squash and forwarding control for the 5-stage pipeline
//   clk, reset                     clock, asynchronous active-high reset
//   rs_id, rt_id, branch_id,       ID instruction sources and class
//   hilo_rd_id, muldiv_id, branch_taken_id
//   rs_ex, rt_ex                   EX instruction sources
//   valid_*, reg_wr_*, rd_*,       per-stage writer information (EX/MEM/WB)
//   mem_to_reg_ex/_mem
//   muldiv_start_ex                mult/div issued in EX
//   stall_if, stall_id, clr_id, clr_ex   pipe register control
//   fwd_a_ex, fwd_b_ex             EX operand source (FWD_RF/FWD_WB/FWD_MEM)
//   fwd_a_id, fwd_b_id             ID compare operand from MEM alu result
//   muldiv_busy                    mult/div in flight
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MULDIV_LAT = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       branch_id,
    input  logic       hilo_rd_id,
    input  logic       muldiv_id,
    input  logic       branch_taken_id,
    input  logic [4:0] rs_ex,
    input  logic [4:0] rt_ex,
    input  logic       valid_ex,
    input  logic       valid_mem,
    input  logic       valid_wb,
    input  logic       reg_wr_ex,
    input  logic       reg_wr_mem,
    input  logic       reg_wr_wb,
    input  logic       mem_to_reg_ex,
    input  logic       mem_to_reg_mem,
    input  logic [4:0] rd_ex,
    input  logic [4:0] rd_mem,
    input  logic [4:0] rd_wb,
    input  logic       muldiv_start_ex,
    output logic       stall_if,
    output logic       stall_id,
    output logic       clr_id,
    output logic       clr_ex,
    output logic [1:0] fwd_a_ex,
    output logic [1:0] fwd_b_ex,
    output logic       fwd_a_id,
    output logic       fwd_b_id,
    output logic       muldiv_busy
);
    logic busy;

    muldiv_tracker #(.MULDIV_LAT(MULDIV_LAT), .CNT_W(CNT_W)) u_tracker (
        .clk             (clk),
        .reset           (reset),
        .muldiv_start_ex (muldiv_start_ex),
        .muldiv_busy     (busy)
    );

    logic rs_ex_mem, rt_ex_mem, rs_ex_wb, rt_ex_wb;
    logic rs_id_ex, rt_id_ex, rs_id_mem, rt_id_mem;
    logic id_dep_ex, id_dep_mem;
    logic lw_stall, br_stall, md_stall, stall;
    logic [1:0] fa, fb;

    assign rs_ex_mem = reg_match(rs_ex, valid_mem, reg_wr_mem, rd_mem);
    assign rt_ex_mem = reg_match(rt_ex, valid_mem, reg_wr_mem, rd_mem);
    assign rs_ex_wb  = reg_match(rs_ex, valid_wb, reg_wr_wb, rd_wb);
    assign rt_ex_wb  = reg_match(rt_ex, valid_wb, reg_wr_wb, rd_wb);
    assign rs_id_ex  = reg_match(rs_id, valid_ex, reg_wr_ex, rd_ex);
    assign rt_id_ex  = reg_match(rt_id, valid_ex, reg_wr_ex, rd_ex);
    assign rs_id_mem = reg_match(rs_id, valid_mem, reg_wr_mem, rd_mem);
    assign rt_id_mem = reg_match(rt_id, valid_mem, reg_wr_mem, rd_mem);

    assign id_dep_ex  = rs_id_ex | rt_id_ex;
    assign id_dep_mem = rs_id_mem | rt_id_mem;

    // A load in MEM has no alu result to forward; its data arrives from WB next cycle.
    assign fa = (rs_ex_mem & !mem_to_reg_mem) ? FWD_MEM : rs_ex_wb ? FWD_WB : FWD_RF;
    assign fb = (rt_ex_mem & !mem_to_reg_mem) ? FWD_MEM : rt_ex_wb ? FWD_WB : FWD_RF;

    assign lw_stall = id_dep_ex & mem_to_reg_ex;
    assign br_stall = branch_id & (id_dep_ex | (id_dep_mem & mem_to_reg_mem));
    // busy rises a cycle after start, so the start cycle itself is covered here.
    assign md_stall = (hilo_rd_id | muldiv_id) & (busy | muldiv_start_ex);
    assign stall    = lw_stall | br_stall | md_stall;

    assign stall_if    = !reset & stall;
    assign stall_id    = !reset & stall;
    assign clr_ex      = !reset & stall;
    assign clr_id      = !reset & branch_taken_id & !stall;
    assign fwd_a_ex    = reset ? FWD_RF : fa;
    assign fwd_b_ex    = reset ? FWD_RF : fb;
    assign fwd_a_id    = !reset & rs_id_mem & !mem_to_reg_mem;
    assign fwd_b_id    = !reset & rt_id_mem & !mem_to_reg_mem;
    assign muldiv_busy = !reset & busy;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb;
    logic       branch_id, hilo_rd_id, muldiv_id, branch_taken_id;
    logic       valid_ex, valid_mem, valid_wb, reg_wr_ex, reg_wr_mem, reg_wr_wb;
    logic       mem_to_reg_ex, mem_to_reg_mem, muldiv_start_ex;
    logic       stall_if, stall_id, clr_id, clr_ex, fwd_a_id, fwd_b_id, muldiv_busy;
    logic [1:0] fwd_a_ex, fwd_b_ex;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .rs_id(rs_id), .rt_id(rt_id), .branch_id(branch_id), .hilo_rd_id(hilo_rd_id),
        .muldiv_id(muldiv_id), .branch_taken_id(branch_taken_id),
        .rs_ex(rs_ex), .rt_ex(rt_ex),
        .valid_ex(valid_ex), .valid_mem(valid_mem), .valid_wb(valid_wb),
        .reg_wr_ex(reg_wr_ex), .reg_wr_mem(reg_wr_mem), .reg_wr_wb(reg_wr_wb),
        .mem_to_reg_ex(mem_to_reg_ex), .mem_to_reg_mem(mem_to_reg_mem),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .muldiv_start_ex(muldiv_start_ex),
        .stall_if(stall_if), .stall_id(stall_id), .clr_id(clr_id), .clr_ex(clr_ex),
        .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex), .fwd_a_id(fwd_a_id), .fwd_b_id(fwd_b_id),
        .muldiv_busy(muldiv_busy)
    );

    typedef struct {
        string       tag;
        logic [10:0] v;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;

    // Expected outputs packed as {stall_if, stall_id, clr_id, clr_ex, fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id, busy}.
    function automatic logic [10:0] ev(input logic st, input logic ci, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic ai, input logic bi,
                                       input logic busy);
        return {st, st, ci, st, fa, fb, ai, bi, busy};
    endfunction

    task automatic clear_inputs();
        {rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb} = '0;
        {branch_id, hilo_rd_id, muldiv_id, branch_taken_id} = '0;
        {valid_ex, valid_mem, valid_wb, reg_wr_ex, reg_wr_mem, reg_wr_wb} = '0;
        {mem_to_reg_ex, mem_to_reg_mem, muldiv_start_ex} = '0;
    endtask

    // Inputs are already driven; queue the expectation, sample at negedge, then step past the next posedge.
    task automatic chk(input string tag, input logic [10:0] v);
        exp_t e;
        logic [10:0] obs;
        q.push_back('{tag: tag, v: v});
        @(negedge clk);
        e   = q.pop_front();
        obs = {stall_if, stall_id, clr_id, clr_ex, fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id, muldiv_busy};
        total++;
        assert (obs === e.v) passed++;
        else $error("FAIL %s: observed %b expected %b", e.tag, obs, e.v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        // Live forwarding/stall conditions must all be masked during reset.
        valid_mem = 1; reg_wr_mem = 1; rd_mem = 5'd3; rs_ex = 5'd3;
        valid_ex = 1; reg_wr_ex = 1; mem_to_reg_ex = 1; rd_ex = 5'd7; rs_id = 5'd7; branch_taken_id = 1;
        chk("reset_outputs", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));
        reset = 1'b0;

        clear_inputs();
        valid_mem = 1; reg_wr_mem = 1; rd_mem = 5'd3;
        valid_wb = 1; reg_wr_wb = 1; rd_wb = 5'd3;
        rs_ex = 5'd3; rt_ex = 5'd3;
        chk("mem_priority", ev(0, 0, 2'b10, 2'b10, 0, 0, 0));

        mem_to_reg_mem = 1;
        chk("load_in_mem_uses_wb", ev(0, 0, 2'b01, 2'b01, 0, 0, 0));

        clear_inputs();
        valid_wb = 1; reg_wr_wb = 1; rd_wb = 5'd9; rt_ex = 5'd9; rs_ex = 5'd8;
        chk("wb_only_b", ev(0, 0, 2'b00, 2'b01, 0, 0, 0));

        valid_wb = 0;
        chk("wb_invalid", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));

        clear_inputs();
        valid_ex = 1; reg_wr_ex = 1; mem_to_reg_ex = 1; rd_ex = 5'd5; rt_id = 5'd5;
        chk("lw_stall", ev(1, 0, 2'b00, 2'b00, 0, 0, 0));

        clear_inputs();
        valid_mem = 1; reg_wr_mem = 1; mem_to_reg_mem = 1; rd_mem = 5'd5; rt_id = 5'd5;
        chk("lw_bubble_cycle", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));

        clear_inputs();
        valid_wb = 1; reg_wr_wb = 1; rd_wb = 5'd5; rt_ex = 5'd5;
        chk("lw_fwd_wb", ev(0, 0, 2'b00, 2'b01, 0, 0, 0));

        clear_inputs();
        valid_ex = 1; reg_wr_ex = 1; rd_ex = 5'd4; rs_id = 5'd4; branch_id = 1; branch_taken_id = 1;
        chk("br_stall_no_clr", ev(1, 0, 2'b00, 2'b00, 0, 0, 0));

        clear_inputs();
        valid_mem = 1; reg_wr_mem = 1; rd_mem = 5'd4; rs_id = 5'd4; branch_id = 1; branch_taken_id = 1;
        chk("br_fwd_id_clr", ev(0, 1, 2'b00, 2'b00, 1, 0, 0));

        clear_inputs();
        valid_mem = 1; reg_wr_mem = 1; mem_to_reg_mem = 1; rd_mem = 5'd6; rt_id = 5'd6; branch_id = 1;
        chk("br_load_mem_stall", ev(1, 0, 2'b00, 2'b00, 0, 0, 0));

        branch_id = 0;
        chk("nonbr_load_mem", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));

        clear_inputs();
        valid_mem = 1; reg_wr_mem = 1; rd_mem = 5'd11; rt_id = 5'd11;
        chk("fwd_b_id", ev(0, 0, 2'b00, 2'b00, 0, 1, 0));

        clear_inputs();
        valid_ex = 1; reg_wr_ex = 1; mem_to_reg_ex = 1;
        valid_mem = 1; reg_wr_mem = 1; valid_wb = 1; reg_wr_wb = 1; branch_id = 1;
        chk("zero_reg", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));

        clear_inputs();
        muldiv_start_ex = 1; hilo_rd_id = 1;
        chk("md_start_cycle", ev(1, 0, 2'b00, 2'b00, 0, 0, 0));
        muldiv_start_ex = 0;
        for (int i = 0; i < 3; i++) chk($sformatf("md_busy_%0d", i), ev(1, 0, 2'b00, 2'b00, 0, 0, 1));
        chk("md_released", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));

        hilo_rd_id = 0; muldiv_id = 1;
        chk("md_idle_no_stall", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));

        clear_inputs();
        muldiv_start_ex = 1;
        chk("md_start2", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));
        muldiv_start_ex = 0; hilo_rd_id = 1;
        chk("md_busy_before_reset", ev(1, 0, 2'b00, 2'b00, 0, 0, 1));
        #2 reset = 1'b1;
        chk("async_reset_busy", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));
        reset = 1'b0;
        chk("idle_after_reset", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
